// File: rtl/sn_width_upsizer.sv
// ============================================================================
// Module      : sn_width_upsizer
// Description : Packs narrow snooper writes into wide packet-memory words.
//               It tracks lane masks and byte counts, flushes a partial word
//               on an address jump or done, and holds one pending word.
//               Optional SN_WIDTH_LANE_MASK_EN adds the out_lane_mask output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sn_width_upsizer #(
    parameter int IN_WIDTH       = 32,
    parameter int RATIO          = 2,
    parameter int IN_ADDR_WIDTH  = 10,
    parameter int OUT_WIDTH      = IN_WIDTH * RATIO,
    parameter int N              = $clog2(RATIO),
    parameter int OUT_ADDR_WIDTH = IN_ADDR_WIDTH - N,
    parameter int IN_INC_WIDTH   = $clog2(IN_WIDTH / 8) + 1,
    parameter int OUT_INC_WIDTH  = $clog2(OUT_WIDTH / 8) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_ADDR_WIDTH-1:0]  in_addr,
    input  logic [IN_WIDTH-1:0]       in_wr_data,
    input  logic                      in_wr_en,
    input  logic [IN_INC_WIDTH-1:0]   in_byte_inc,
    input  logic                      in_done,
    output logic [OUT_ADDR_WIDTH-1:0] out_addr,
    output logic [OUT_WIDTH-1:0]      out_wr_data,
    output logic                      out_wr_en,
    output logic [OUT_INC_WIDTH-1:0]  out_byte_inc,
    output logic                      out_done,
    output logic                      out_err
`ifdef SN_WIDTH_LANE_MASK_EN
    ,
    output logic [RATIO-1:0]          out_lane_mask
`endif
);

    localparam int LANE_W = (N == 0) ? 1 : N;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t                      r_state, w_state_nx;
    logic [OUT_WIDTH-1:0]        r_acc_data, w_acc_data_nx;
    logic [RATIO-1:0]            r_acc_mask, w_acc_mask_nx;
    logic [OUT_INC_WIDTH-1:0]    r_acc_cnt, w_acc_cnt_nx;
    logic [OUT_ADDR_WIDTH-1:0]   r_acc_hi, w_acc_hi_nx;
    logic [OUT_WIDTH-1:0]        r_pend_data, w_pend_data_nx;
    logic [RATIO-1:0]            r_pend_mask, w_pend_mask_nx;
    logic [OUT_INC_WIDTH-1:0]    r_pend_cnt, w_pend_cnt_nx;
    logic [OUT_ADDR_WIDTH-1:0]   r_pend_hi, w_pend_hi_nx;
    logic                        r_pend_done, w_pend_done_nx;

    logic [LANE_W-1:0]           w_lane;
    logic [OUT_ADDR_WIDTH-1:0]   w_hi;
    logic [OUT_WIDTH-1:0]        w_lane_data, w_merge_data;
    logic [RATIO-1:0]            w_lane_bit, w_merge_mask;
    logic [OUT_INC_WIDTH-1:0]    w_inc_ext, w_merge_cnt;
    logic                        w_trig;

    logic                        w_emit, w_emit_done, w_err_nx;
    logic [OUT_WIDTH-1:0]        w_emit_data;
    logic [RATIO-1:0]            w_emit_mask;
    logic [OUT_INC_WIDTH-1:0]    w_emit_cnt;
    logic [OUT_ADDR_WIDTH-1:0]   w_emit_addr;

    function automatic logic [OUT_WIDTH-1:0] f_expand(input logic [RATIO-1:0] m);
        logic [OUT_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < RATIO; i++) begin
            v[i*IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{m[i]}};
        end
        return v;
    endfunction

    generate
        if (N == 0) begin : g_lane_single
            assign w_lane = '0;
            assign w_hi   = in_addr;
        end else begin : g_lane_multi
            assign w_lane = in_addr[LANE_W-1:0];
            assign w_hi   = in_addr[IN_ADDR_WIDTH-1:N];
        end
    endgenerate

    // Lane 0 lives in the MSBs, so mask bit RATIO-1-lane tracks lane 'lane'.
    always_comb begin
        w_lane_data = '0;
        w_lane_bit  = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (w_lane == LANE_W'(l)) begin
                w_lane_data[(RATIO-1-l)*IN_WIDTH +: IN_WIDTH] = in_wr_data;
                w_lane_bit[RATIO-1-l] = 1'b1;
            end
        end
        w_inc_ext    = OUT_INC_WIDTH'(in_byte_inc);
        w_merge_data = (r_acc_data & ~f_expand(w_lane_bit)) | w_lane_data;
        w_merge_mask = r_acc_mask | w_lane_bit;
        w_merge_cnt  = r_acc_cnt + w_inc_ext;
        w_trig       = (w_lane == LANE_W'(RATIO - 1)) | in_done;
    end

    always_comb begin
        w_state_nx     = r_state;
        w_acc_data_nx  = r_acc_data;
        w_acc_mask_nx  = r_acc_mask;
        w_acc_cnt_nx   = r_acc_cnt;
        w_acc_hi_nx    = r_acc_hi;
        w_pend_data_nx = r_pend_data;
        w_pend_mask_nx = r_pend_mask;
        w_pend_cnt_nx  = r_pend_cnt;
        w_pend_hi_nx   = r_pend_hi;
        w_pend_done_nx = r_pend_done;
        w_emit         = 1'b0;
        w_emit_done    = 1'b0;
        w_emit_data    = '0;
        w_emit_mask    = '0;
        w_emit_cnt     = '0;
        w_emit_addr    = '0;
        w_err_nx       = out_err;

        case (r_state)
            S_IDLE, S_FILL: begin
                if (in_wr_en) begin
                    if (r_state == S_FILL && w_hi != r_acc_hi) begin
                        w_emit      = 1'b1;
                        w_emit_data = r_acc_data;
                        w_emit_mask = r_acc_mask;
                        w_emit_cnt  = r_acc_cnt;
                        w_emit_addr = r_acc_hi;
                        if (w_trig) begin
                            // The new word also completes: park it for next cycle.
                            w_pend_data_nx = w_lane_data;
                            w_pend_mask_nx = w_lane_bit;
                            w_pend_cnt_nx  = w_inc_ext;
                            w_pend_hi_nx   = w_hi;
                            w_pend_done_nx = in_done;
                            w_acc_data_nx  = '0;
                            w_acc_mask_nx  = '0;
                            w_acc_cnt_nx   = '0;
                            w_acc_hi_nx    = '0;
                            w_state_nx     = S_PEND;
                        end else begin
                            w_acc_data_nx = w_lane_data;
                            w_acc_mask_nx = w_lane_bit;
                            w_acc_cnt_nx  = w_inc_ext;
                            w_acc_hi_nx   = w_hi;
                            w_state_nx    = S_FILL;
                        end
                    end else if (w_trig) begin
                        w_emit        = 1'b1;
                        w_emit_data   = w_merge_data;
                        w_emit_mask   = w_merge_mask;
                        w_emit_cnt    = w_merge_cnt;
                        w_emit_addr   = w_hi;
                        w_emit_done   = in_done;
                        w_acc_data_nx = '0;
                        w_acc_mask_nx = '0;
                        w_acc_cnt_nx  = '0;
                        w_acc_hi_nx   = '0;
                        w_state_nx    = S_IDLE;
                    end else begin
                        w_acc_data_nx = w_merge_data;
                        w_acc_mask_nx = w_merge_mask;
                        w_acc_cnt_nx  = w_merge_cnt;
                        w_acc_hi_nx   = w_hi;
                        w_state_nx    = S_FILL;
                    end
                end else if (in_done) begin
                    w_emit_done = 1'b1;
                    if (r_state == S_FILL) begin
                        w_emit        = 1'b1;
                        w_emit_data   = r_acc_data;
                        w_emit_mask   = r_acc_mask;
                        w_emit_cnt    = r_acc_cnt;
                        w_emit_addr   = r_acc_hi;
                        w_acc_data_nx = '0;
                        w_acc_mask_nx = '0;
                        w_acc_cnt_nx  = '0;
                        w_acc_hi_nx   = '0;
                        w_state_nx    = S_IDLE;
                    end
                end
            end
            S_PEND: begin
                w_emit         = 1'b1;
                w_emit_data    = r_pend_data;
                w_emit_mask    = r_pend_mask;
                w_emit_cnt     = r_pend_cnt;
                w_emit_addr    = r_pend_hi;
                w_emit_done    = r_pend_done | (in_done & ~in_wr_en);
                w_pend_data_nx = '0;
                w_pend_mask_nx = '0;
                w_pend_cnt_nx  = '0;
                w_pend_hi_nx   = '0;
                w_pend_done_nx = 1'b0;
                w_state_nx     = S_IDLE;
                if (in_wr_en) begin
                    // The output slot is taken: a write needing it is lost.
                    if (w_trig) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_acc_data_nx = w_lane_data;
                        w_acc_mask_nx = w_lane_bit;
                        w_acc_cnt_nx  = w_inc_ext;
                        w_acc_hi_nx   = w_hi;
                        w_state_nx    = S_FILL;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc_data   <= '0;
            r_acc_mask   <= '0;
            r_acc_cnt    <= '0;
            r_acc_hi     <= '0;
            r_pend_data  <= '0;
            r_pend_mask  <= '0;
            r_pend_cnt   <= '0;
            r_pend_hi    <= '0;
            r_pend_done  <= 1'b0;
            out_addr     <= '0;
            out_wr_data  <= '0;
            out_wr_en    <= 1'b0;
            out_byte_inc <= '0;
            out_done     <= 1'b0;
            out_err      <= 1'b0;
`ifdef SN_WIDTH_LANE_MASK_EN
            out_lane_mask <= '0;
`endif
        end else begin
            r_state      <= w_state_nx;
            r_acc_data   <= w_acc_data_nx;
            r_acc_mask   <= w_acc_mask_nx;
            r_acc_cnt    <= w_acc_cnt_nx;
            r_acc_hi     <= w_acc_hi_nx;
            r_pend_data  <= w_pend_data_nx;
            r_pend_mask  <= w_pend_mask_nx;
            r_pend_cnt   <= w_pend_cnt_nx;
            r_pend_hi    <= w_pend_hi_nx;
            r_pend_done  <= w_pend_done_nx;
            out_addr     <= w_emit_addr;
            out_wr_data  <= w_emit_data & f_expand(w_emit_mask);
            out_wr_en    <= w_emit;
            out_byte_inc <= w_emit_cnt;
            out_done     <= w_emit_done;
            out_err      <= w_err_nx;
`ifdef SN_WIDTH_LANE_MASK_EN
            out_lane_mask <= w_emit_mask;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sn_width_upsizer.sv
// ============================================================================
// Module      : tb_sn_width_upsizer
// Description : Scoreboard bench for sn_width_upsizer at RATIO=2 and RATIO=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sn_width_upsizer;

    typedef struct {
        int          cyc;
        logic        en;
        logic [9:0]  addr;
        logic [63:0] data;
        logic [3:0]  inc;
        logic        done;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        q2[$];
    exp_t        q1[$];

    // RATIO=2 instance
    logic [9:0]  a2 = '0;
    logic [31:0] d2 = '0;
    logic        en2 = 1'b0;
    logic [2:0]  inc2 = '0;
    logic        dn2 = 1'b0;
    logic [8:0]  o2_addr;
    logic [63:0] o2_data;
    logic        o2_en;
    logic [3:0]  o2_inc;
    logic        o2_done;
    logic        o2_err;

    // RATIO=1 instance
    logic [9:0]  a1 = '0;
    logic [31:0] d1 = '0;
    logic        en1 = 1'b0;
    logic [2:0]  inc1 = '0;
    logic        dn1 = 1'b0;
    logic [9:0]  o1_addr;
    logic [31:0] o1_data;
    logic        o1_en;
    logic [2:0]  o1_inc;
    logic        o1_done;
    logic        o1_err;

`ifdef SN_WIDTH_LANE_MASK_EN
    logic [1:0]  o2_lmask;
    logic [0:0]  o1_lmask;
`endif

    sn_width_upsizer #(.IN_WIDTH(32), .RATIO(2), .IN_ADDR_WIDTH(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_addr      (a2),
        .in_wr_data   (d2),
        .in_wr_en     (en2),
        .in_byte_inc  (inc2),
        .in_done      (dn2),
        .out_addr     (o2_addr),
        .out_wr_data  (o2_data),
        .out_wr_en    (o2_en),
        .out_byte_inc (o2_inc),
        .out_done     (o2_done),
        .out_err      (o2_err)
`ifdef SN_WIDTH_LANE_MASK_EN
        ,
        .out_lane_mask(o2_lmask)
`endif
    );

    sn_width_upsizer #(.IN_WIDTH(32), .RATIO(1), .IN_ADDR_WIDTH(10)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .in_addr      (a1),
        .in_wr_data   (d1),
        .in_wr_en     (en1),
        .in_byte_inc  (inc1),
        .in_done      (dn1),
        .out_addr     (o1_addr),
        .out_wr_data  (o1_data),
        .out_wr_en    (o1_en),
        .out_byte_inc (o1_inc),
        .out_done     (o1_done),
        .out_err      (o1_err)
`ifdef SN_WIDTH_LANE_MASK_EN
        ,
        .out_lane_mask(o1_lmask)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input int c, input logic en, input logic [9:0] addr,
                                input logic [63:0] data, input logic [3:0] inc,
                                input logic done, input logic err);
        exp_t e;
        e.cyc = c; e.en = en; e.addr = addr; e.data = data;
        e.inc = inc; e.done = done; e.err = err;
        return e;
    endfunction

    // Monitors: pop one expected entry per presented output.
    always @(negedge clk) begin
        if (o2_en || o2_done) begin
            exp_t e;
            n_tests++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL r2_unexpected: cyc=%0d en=%b addr=%h data=%h inc=%0d done=%b, required no output",
                         cyc, o2_en, o2_addr, o2_data, o2_inc, o2_done);
            end else begin
                e = q2.pop_front();
                if (e.cyc != cyc || o2_en !== e.en || {1'b0, o2_addr} !== e.addr ||
                    o2_data !== e.data || o2_inc !== e.inc || o2_done !== e.done ||
                    o2_err !== e.err) begin
                    n_fail++;
                    $display("FAIL r2_out: got cyc=%0d en=%b addr=%h data=%h inc=%0d done=%b err=%b; required cyc=%0d en=%b addr=%h data=%h inc=%0d done=%b err=%b",
                             cyc, o2_en, o2_addr, o2_data, o2_inc, o2_done, o2_err,
                             e.cyc, e.en, e.addr, e.data, e.inc, e.done, e.err);
                end
            end
        end
        if (o1_en || o1_done) begin
            exp_t e;
            n_tests++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL r1_unexpected: cyc=%0d en=%b addr=%h data=%h, required no output",
                         cyc, o1_en, o1_addr, o1_data);
            end else begin
                e = q1.pop_front();
                if (e.cyc != cyc || o1_en !== e.en || o1_addr !== e.addr ||
                    {32'h0, o1_data} !== e.data || {1'b0, o1_inc} !== e.inc ||
                    o1_done !== e.done || o1_err !== e.err) begin
                    n_fail++;
                    $display("FAIL r1_out: got cyc=%0d en=%b addr=%h data=%h inc=%0d done=%b err=%b; required cyc=%0d en=%b addr=%h data=%h inc=%0d done=%b err=%b",
                             cyc, o1_en, o1_addr, o1_data, o1_inc, o1_done, o1_err,
                             e.cyc, e.en, e.addr, e.data, e.inc, e.done, e.err);
                end
            end
        end
    end

    task automatic step2(input logic en, input logic [9:0] a, input logic [31:0] d,
                         input logic [2:0] inc, input logic dn);
        en2 = en; a2 = a; d2 = d; inc2 = inc; dn2 = dn;
        @(posedge clk); #1;
        en2 = 1'b0; a2 = '0; d2 = '0; inc2 = '0; dn2 = 1'b0;
    endtask

    task automatic step1(input logic en, input logic [9:0] a, input logic [31:0] d,
                         input logic [2:0] inc, input logic dn);
        en1 = en; a1 = a; d1 = d; inc1 = inc; dn1 = dn;
        @(posedge clk); #1;
        en1 = 1'b0; a1 = '0; d1 = '0; inc1 = '0; dn1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (o2_en !== 1'b0 || o2_addr !== '0 || o2_data !== '0 || o2_inc !== '0 ||
            o2_done !== 1'b0 || o2_err !== 1'b0 || o1_en !== 1'b0 || o1_data !== '0 ||
            o1_done !== 1'b0 || o1_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got en=%b addr=%h data=%h inc=%0d done=%b err=%b r1en=%b r1done=%b, required all zero",
                     name, o2_en, o2_addr, o2_data, o2_inc, o2_done, o2_err, o1_en, o1_done);
        end
    endtask

    task automatic check_err(input string name, input logic want);
        n_tests++;
        if (o2_err !== want) begin
            n_fail++;
            $display("FAIL %s: got out_err=%b, required %b", name, o2_err, want);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle(2);
        check_zero("reset_state");
        rst = 1'b0;
        idle(1);

        // Two lanes fill one wide word.
        step2(1, 10'h010, 32'hAAAAAAAA, 3'd4, 0);
        q2.push_back(mk(cyc + 1, 1, 10'h008, 64'hAAAAAAAA_BBBBBBBB, 4'd8, 0, 0));
        step2(1, 10'h011, 32'hBBBBBBBB, 3'd4, 0);
        idle(2);

        // Write with done flushes a half word, low lane zero.
        q2.push_back(mk(cyc + 1, 1, 10'h010, 64'hCCCCCCCC_00000000, 4'd4, 1, 0));
        step2(1, 10'h020, 32'hCCCCCCCC, 3'd4, 1);
        idle(2);

        // Jump with a completing write: old word, then the pending word.
        step2(1, 10'h030, 32'h11111111, 3'd4, 0);
        q2.push_back(mk(cyc + 1, 1, 10'h018, 64'h11111111_00000000, 4'd4, 0, 0));
        q2.push_back(mk(cyc + 2, 1, 10'h020, 64'h00000000_22222222, 4'd2, 1, 0));
        step2(1, 10'h041, 32'h22222222, 3'd2, 1);
        idle(3);

        // Standalone done in FILL, then in IDLE; byte_inc of 3.
        step2(1, 10'h0A0, 32'hDDDDDDDD, 3'd3, 0);
        q2.push_back(mk(cyc + 1, 1, 10'h050, 64'hDDDDDDDD_00000000, 4'd3, 1, 0));
        step2(0, 10'h000, 32'h0, 3'd0, 1);
        q2.push_back(mk(cyc + 1, 0, 10'h000, 64'h0, 4'd0, 1, 0));
        step2(0, 10'h000, 32'h0, 3'd0, 1);
        idle(2);

        // Overflow: last-lane write while the pending slot drains.
        step2(1, 10'h070, 32'h44444444, 3'd4, 0);
        q2.push_back(mk(cyc + 1, 1, 10'h038, 64'h44444444_00000000, 4'd4, 0, 0));
        q2.push_back(mk(cyc + 2, 1, 10'h040, 64'h00000000_55555555, 4'd4, 0, 1));
        step2(1, 10'h081, 32'h55555555, 3'd4, 0);
        step2(1, 10'h091, 32'h66666666, 3'd4, 0);
        idle(4);
        check_err("err_sticky", 1'b1);

        // Reset while a partial word is held discards it.
        step2(1, 10'h050, 32'h77777777, 3'd4, 0);
        rst = 1'b1;
        idle(1);
        check_zero("reset_in_fill");
        rst = 1'b0;
        q2.push_back(mk(cyc + 1, 1, 10'h030, 64'h00000000_33333333, 4'd4, 0, 0));
        step2(1, 10'h061, 32'h33333333, 3'd4, 0);
        idle(2);
        check_err("err_cleared", 1'b0);

        // RATIO=1: every write emits; standalone done pulses alone.
        q1.push_back(mk(cyc + 1, 1, 10'h005, 64'h12345678, 4'd4, 0, 0));
        step1(1, 10'h005, 32'h12345678, 3'd4, 0);
        q1.push_back(mk(cyc + 1, 0, 10'h000, 64'h0, 4'd0, 1, 0));
        step1(0, 10'h000, 32'h0, 3'd0, 1);
        q1.push_back(mk(cyc + 1, 1, 10'h3FF, 64'hFFFFFFFF, 4'd0, 1, 0));
        step1(1, 10'h3FF, 32'hFFFFFFFF, 3'd0, 1);
        idle(3);

        n_tests++;
        if (q2.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL missing_outputs: got %0d/%0d entries left, required 0/0",
                     q2.size(), q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sn_width_upsizer.md
Name: sn_width_upsizer

Overview:
- Registered, parametrised successor to the snooper-side width adapter. Sits between a narrow snooper (IN_WIDTH) and a wide packet-memory write port (OUT_WIDTH = RATIO*IN_WIDTH, RATIO any power of two including 1).
- Accumulates narrow writes into a wide word and tracks a per-lane valid mask and a byte count.
- Flushes a partial word on non-sequential address jumps and on a standalone done.
- Has a one-entry pending slot so a jump never loses data, plus a sticky overflow flag.

Parameters:
- IN_WIDTH, 32: snooper data width, multiple of 8.
- RATIO, 2: OUT_WIDTH/IN_WIDTH; power of two, 1..16.
- IN_ADDR_WIDTH, 10: snooper word-address width.
- OUT_WIDTH, IN_WIDTH*RATIO: derived; do not override.
- N, CLOG2(RATIO): derived; lane-select bits.
- OUT_ADDR_WIDTH, IN_ADDR_WIDTH-N: derived.
- IN_INC_WIDTH, CLOG2(IN_WIDTH/8)+1: snooper byte-increment width.
- OUT_INC_WIDTH, CLOG2(OUT_WIDTH/8)+1: output byte-count width; OUT_WIDTH/8 is representable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_addr  in  IN_ADDR_WIDTH  snooper word address
- in_wr_data  in  IN_WIDTH  write data
- in_wr_en  in  1  write strobe
- in_byte_inc  in  IN_INC_WIDTH  valid bytes in this write, 0..IN_WIDTH/8
- in_done  in  1  end of packet; may coincide with in_wr_en or arrive alone
- out_addr  out  OUT_ADDR_WIDTH  wide-word address
- out_wr_data  out  OUT_WIDTH  wide word
- out_wr_en  out  1  wide write strobe
- out_byte_inc  out  OUT_INC_WIDTH  valid bytes in emitted word
- out_done  out  1  packet-done pulse
- out_err  out  1  sticky overflow flag

Behaviour:
- One clock, synchronous active-high reset. All outputs are registered and reset to 0. rst also clears the accumulator, mask, count, pending slot and state, and takes priority over every input in the same cycle. A partial word held at reset is discarded.
- Lane mapping: lane = in_addr[N-1:0]. Lane 0 occupies the MSBs (bits OUT_WIDTH-1 down to OUT_WIDTH-IN_WIDTH). Word index hi = in_addr[IN_ADDR_WIDTH-1:N]. Lanes never written in an emitted word read as 0.
- Accumulator state: acc_data, acc_mask[RATIO], acc_cnt, acc_hi.
- FSM states:
  - IDLE: accumulator empty.
  - FILL: partial word held.
  - PEND: a completed word waits in the pending slot.
- Write, same hi as acc_hi or from IDLE: merge data into lane, set mask bit, acc_cnt += in_byte_inc, acc_hi = hi.
  - Emit if lane == RATIO-1 or in_done.
  - Otherwise go to (or stay in) FILL.
- Emit: on the next cycle out_wr_en=1, out_addr=hi, out_wr_data = merged word including this write, out_byte_inc = acc_cnt + in_byte_inc, out_done = in_done. Accumulator clears; state goes to IDLE. Latency is exactly 1 cycle.
- Jump (FILL, in_wr_en, hi != acc_hi): the old partial word is emitted next cycle at acc_hi with its old count, out_done=0. The new write starts a fresh accumulator.
  - If that new write also triggers an emit (last lane or in_done), it moves to the pending slot and state goes to PEND.
  - The pending word is emitted on the following cycle, carrying its own out_done.
- PEND: the pending word is emitted this cycle. A concurrent write accumulates normally. If that write would also need an output this cycle, the write is dropped and out_err is set (sticky until rst).
- Standalone in_done (no in_wr_en):
  - In FILL: flush the partial word with out_done=1.
  - In IDLE: pulse out_done=1 with out_wr_en=0.
  - In PEND: out_done is ORed onto the pending emit.
- in_byte_inc=0 writes still set the mask bit and count as lane writes.
- RATIO=1 (N=0): every write emits. The block is a 1-cycle register stage; jump and PEND logic are never exercised.
- acc_cnt never wraps under legal input, since the maximum equals OUT_WIDTH/8.

Optional Feature:
- Macro SN_WIDTH_LANE_MASK_EN.
- Defined: adds output out_lane_mask [RATIO-1:0], registered alongside out_wr_data. Bit RATIO-1-lane is set for each lane written into the emitted word (same MSB-first ordering as the data). Resets to 0, and is 0 when out_wr_en=0.
- Undefined: port absent; mask logic is still used internally for zero-fill.

Test Plan:
- RATIO=2, IN_WIDTH=32: writes addr 0x10 data 0xAAAAAAAA inc 4, then addr 0x11 data 0xBBBBBBBB inc 4 -> one cycle later out_wr_en=1, out_addr=0x08, out_wr_data=0xAAAAAAAABBBBBBBB, out_byte_inc=8.
- Write addr 0x20 inc 4 with in_done=1 -> out_addr=0x10, out_wr_data=0xCCCCCCCC00000000, out_byte_inc=4, out_done=1.
- Jump: write addr 0x30 inc 4, then addr 0x41 inc 2 with in_done -> cycle+1: out_addr=0x18, out_byte_inc=4, out_done=0. Cycle+2: out_addr=0x20, out_byte_inc=2, out_done=1, out_wr_data low lane set, high lane 0.
- Overflow: trigger PEND, then a last-lane write in the PEND cycle -> pending word emitted, out_err=1 and it stays 1 until rst.
- rst asserted while in FILL (addr 0x50 held) -> next cycle all outputs 0. A following write to addr 0x61 emits with out_byte_inc equal to that write only.
- RATIO=1: write addr 0x5 data 0x12345678 -> next cycle out_addr=0x5, out_wr_data=0x12345678. A standalone in_done in IDLE gives out_done=1 with out_wr_en=0.
